// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetch front end: FSM states,
// RISC-V control-transfer opcodes and the sequential PC step.
package instruction_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_PREDICT = 2'd1,
    ST_ISSUE   = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bundle of the fetcher's icache, predictor, instruction-queue and redirect signals.
// Handshakes: icacheReqValid is a level held until a one-cycle icacheRespValid pulse;
// the queue transfer happens on a rising edge where iqValid && iqReady, and iq* hold
// steady while iqReady is low.
interface instruction_fetcher_if;
  logic        icacheReqValid;
  logic [31:0] icacheAddr;
  logic        icacheRespValid;
  logic [31:0] icacheInstr;
  logic        predInstrValid;
  logic [31:0] predInstr;
  logic [31:0] predAddr;
  logic        predJump;
  logic        iqValid;
  logic        iqReady;
  logic [31:0] iqInstr;
  logic [31:0] iqPC;
  logic        iqPredTaken;
  logic        flushIn;
  logic [31:0] flushPC;

  modport master (
    output icacheReqValid, icacheAddr,
    input  icacheRespValid, icacheInstr,
    output predInstrValid, predInstr, predAddr,
    input  predJump,
    output iqValid, iqInstr, iqPC, iqPredTaken,
    input  iqReady,
    input  flushIn, flushPC
  );

  modport slave (
    input  icacheReqValid, icacheAddr,
    output icacheRespValid, icacheInstr,
    input  predInstrValid, predInstr, predAddr,
    output predJump,
    input  iqValid, iqInstr, iqPC, iqPredTaken,
    output iqReady,
    output flushIn, flushPC
  );
endinterface

// File: rtl/instruction_fetcher_next_pc.sv
// Combinational next-PC selection for one fetched word: decodes the B/J immediates
// and picks the sequential or predicted target.
module instruction_fetcher_next_pc
  import instruction_fetcher_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        pred_jump,
  output logic [31:0] next_pc,
  output logic        pred_taken
);

  logic [31:0] imm_b;
  logic [31:0] imm_j;

  // Scrambled RISC-V immediate fields, sign-extended from bit 31.
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    next_pc    = pc + PC_STEP;
    pred_taken = 1'b0;
    case (opcode_of(instr))
      OPC_JAL: begin
        next_pc    = pc + imm_j;
        pred_taken = 1'b1;
      end
      OPC_BRANCH: begin
        if (pred_jump) begin
          next_pc    = pc + imm_b;
          pred_taken = 1'b1;
        end
      end
      OPC_JALR: begin
        // Register target is unknown here; the ROB resolves it.
        next_pc    = pc + PC_STEP;
        pred_taken = 1'b0;
      end
      default: begin
        next_pc    = pc + PC_STEP;
        pred_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Single-outstanding instruction fetcher: FETCH -> PREDICT -> ISSUE, with ROB flush
// redirect and dropping of responses that belong to a flushed request.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  instruction_fetcher_if.master bus,
  output fetch_state_e          state
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] next_pc_q;
  logic        discard;
  logic        pending;
  logic [31:0] iq_instr_q;
  logic [31:0] iq_pc_q;
  logic        iq_taken_q;

  logic        resp_ok;
  logic        transfer;
  logic [31:0] calc_next_pc;
  logic        calc_taken;

  assign state    = state_q;
  assign resp_ok  = (state_q == ST_FETCH) && bus.icacheRespValid && !discard && !bus.flushIn;
  assign transfer = (state_q == ST_ISSUE) && bus.iqReady && !bus.flushIn;

  instruction_fetcher_next_pc u_next_pc (
    .pc         (pc),
    .instr      (instr_q),
    .pred_jump  (bus.predJump),
    .next_pc    (calc_next_pc),
    .pred_taken (calc_taken)
  );

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flushIn) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:   if (resp_ok) state_d = ST_PREDICT;
        ST_PREDICT: state_d = ST_ISSUE;
        ST_ISSUE:   if (bus.iqReady) state_d = ST_FETCH;
        default:    state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.icacheReqValid = (state_q == ST_FETCH) && !discard && !bus.flushIn && !resetIn;
    bus.icacheAddr     = pc;
    bus.predInstrValid = resp_ok && !resetIn;
    bus.predInstr      = 32'd0;
    bus.predAddr       = 32'd0;
    if (resp_ok && !resetIn) begin
      bus.predInstr = bus.icacheInstr;
      bus.predAddr  = pc;
    end
    bus.iqValid     = (state_q == ST_ISSUE) && !resetIn;
    bus.iqInstr     = iq_instr_q;
    bus.iqPC        = iq_pc_q;
    bus.iqPredTaken = iq_taken_q;
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      pc         <= RESET_PC;
      instr_q    <= 32'd0;
      next_pc_q  <= 32'd0;
      discard    <= 1'b0;
      pending    <= 1'b0;
      iq_instr_q <= 32'd0;
      iq_pc_q    <= 32'd0;
      iq_taken_q <= 1'b0;
    end else begin
      // pending: the icache has seen a request it has not answered yet.
      if (bus.icacheRespValid)     pending <= 1'b0;
      else if (bus.icacheReqValid) pending <= 1'b1;

      // A flush that orphans an outstanding request must swallow its late response.
      if (bus.icacheRespValid)             discard <= 1'b0;
      else if (bus.flushIn && pending)     discard <= 1'b1;

      if (bus.flushIn)   pc <= bus.flushPC;
      else if (transfer) pc <= next_pc_q;

      if (resp_ok) instr_q <= bus.icacheInstr;

      if ((state_q == ST_PREDICT) && !bus.flushIn) begin
        next_pc_q  <= calc_next_pc;
        iq_instr_q <= instr_q;
        iq_pc_q    <= pc;
        iq_taken_q <= calc_taken;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios plus a randomized
// instruction stream compared against a PC-level reference model.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int W = 65;
  localparam int K_OTHER = 0, K_JAL = 1, K_BR = 2, K_JALR = 3;

  logic clockIn = 1'b0;
  logic resetIn;
  fetch_state_e state;

  instruction_fetcher_if bus();

  instruction_fetcher #(.RESET_PC(RST_PC)) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .bus     (bus),
    .state   (state)
  );

  always #5 clockIn = ~clockIn;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] exp_next;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  function automatic logic [31:0] enc_jal(input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] off);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {off[12], off[10:5], regs[9:5], regs[4:0], 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  // Builds a random instruction of the requested kind and reports its offset.
  task automatic gen_instr(input int kind, output logic [31:0] instr, output logic [31:0] off);
    logic [20:0] r21;
    logic [12:0] r13;
    off = 32'd0;
    case (kind)
      K_JAL: begin
        r21 = 21'($urandom); r21[0] = 1'b0;
        off = {{11{r21[20]}}, r21};
        instr = enc_jal(off);
      end
      K_BR: begin
        r13 = 13'($urandom); r13[0] = 1'b0;
        off = {{19{r13[12]}}, r13};
        instr = enc_br(off);
      end
      K_JALR: begin
        instr = $urandom;
        instr[14:12] = 3'b000;
        instr[6:0] = 7'b1100111;
      end
      default: begin
        instr = $urandom;
        if (instr[6:0] == 7'b1101111 || instr[6:0] == 7'b1100011 || instr[6:0] == 7'b1100111)
          instr[6:0] = 7'b0010011;
      end
    endcase
  endtask

  // Runs one word from request to the start of ISSUE and queues its expected record.
  task automatic fetch_to_issue(input logic [31:0] instr, input int kind, input logic [31:0] off,
                                input int lat, input logic pj);
    int n;
    logic taken;
    n = 0;
    #1;
    while (!bus.icacheReqValid && n < 20) begin
      tick(); #1; n++;
    end
    check_eq("req_valid", 32'(bus.icacheReqValid), 32'd1);
    check_eq("req_addr", bus.icacheAddr, model_pc);
    repeat (lat) begin tick(); #1; end
    bus.icacheRespValid = 1'b1;
    bus.icacheInstr = instr;
    #1;
    check_eq("pred_valid", 32'(bus.predInstrValid), 32'd1);
    check_eq("pred_instr", bus.predInstr, instr);
    check_eq("pred_addr", bus.predAddr, model_pc);
    tick();
    bus.icacheRespValid = 1'b0;
    bus.icacheInstr = $urandom;
    bus.predJump = pj;
    #1;
    check_eq("req_idle_predict", 32'(bus.icacheReqValid), 32'd0);
    if (kind == K_JAL) begin
      exp_next = model_pc + off; taken = 1'b1;
    end else if (kind == K_BR && pj) begin
      exp_next = model_pc + off; taken = 1'b1;
    end else begin
      exp_next = model_pc + 32'd4; taken = 1'b0;
    end
    exp_q.push_back({instr, model_pc, taken});
    tick();
    bus.predJump = 1'($urandom);
    #1;
  endtask

  task automatic complete_transfer(input int stall);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("iq_valid", 32'(bus.iqValid), 32'd1);
    check_eq("iq_instr", bus.iqInstr, e[64:33]);
    check_eq("iq_pc", bus.iqPC, e[32:1]);
    check_eq("iq_taken", 32'(bus.iqPredTaken), 32'(e[0]));
    repeat (stall) begin
      tick(); #1;
      check_eq("stall_valid", 32'(bus.iqValid), 32'd1);
      check_eq("stall_instr", bus.iqInstr, e[64:33]);
      check_eq("stall_pc", bus.iqPC, e[32:1]);
      check_eq("stall_no_req", 32'(bus.icacheReqValid), 32'd0);
    end
    bus.iqReady = 1'b1;
    tick();
    bus.iqReady = 1'b0;
    #1;
    check_eq("one_transfer", 32'(bus.iqValid), 32'd0);
    model_pc = exp_next;
  endtask

  // Redirect from the first FETCH cycle, before any request has been seen.
  task automatic redirect(input logic [31:0] target);
    check_eq("pre_redirect_addr", bus.icacheAddr, model_pc);
    bus.flushIn = 1'b1;
    bus.flushPC = target;
    #1;
    check_eq("flush_req_low", 32'(bus.icacheReqValid), 32'd0);
    tick();
    bus.flushIn = 1'b0;
    model_pc = target;
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] off;
    int kind;
    resetIn = 1'b1;
    bus.icacheRespValid = 1'b0;
    bus.icacheInstr = 32'd0;
    bus.predJump = 1'b0;
    bus.iqReady = 1'b0;
    bus.flushIn = 1'b0;
    bus.flushPC = 32'd0;
    model_pc = RST_PC;
    exp_next = RST_PC;

    #12;
    check_eq("rst_state", 32'(state), 32'(ST_FETCH));
    check_eq("rst_req", 32'(bus.icacheReqValid), 32'd0);
    check_eq("rst_iq_valid", 32'(bus.iqValid), 32'd0);
    check_eq("rst_iq_pc", bus.iqPC, 32'd0);
    check_eq("rst_iq_instr", bus.iqInstr, 32'd0);
    check_eq("rst_addr", bus.icacheAddr, RST_PC);
    tick();
    resetIn = 1'b0;

    // ADDI x1,x0,1 straight after reset.
    fetch_to_issue(32'h0010_0093, K_OTHER, 32'd0, 1, 1'b1);
    complete_transfer(0);

    // JAL x0,+0x20 at 0x200; prediction input is irrelevant.
    redirect(32'h0000_0200);
    off = 32'h20;
    fetch_to_issue(enc_jal(off), K_JAL, off, 2, 1'b0);
    complete_transfer(0);

    // BEQ -8 at 0x300, predicted taken then not taken; the second waits 5 cycles in ISSUE.
    redirect(32'h0000_0300);
    off = 32'hFFFF_FFF8;
    fetch_to_issue(enc_br(off), K_BR, off, 0, 1'b1);
    complete_transfer(0);
    redirect(32'h0000_0300);
    fetch_to_issue(enc_br(off), K_BR, off, 3, 1'b0);
    complete_transfer(5);

    // Flush while a request is outstanding: the late response must be swallowed.
    check_eq("pre_flush_req", 32'(bus.icacheReqValid), 32'd1);
    check_eq("pre_flush_addr", bus.icacheAddr, model_pc);
    tick();
    bus.flushIn = 1'b1;
    bus.flushPC = 32'h0000_0400;
    #1;
    check_eq("flush_req_low", 32'(bus.icacheReqValid), 32'd0);
    tick();
    bus.flushIn = 1'b0;
    #1;
    check_eq("discard_req_low", 32'(bus.icacheReqValid), 32'd0);
    tick();
    bus.icacheRespValid = 1'b1;
    bus.icacheInstr = 32'hDEAD_BEEF;
    #1;
    check_eq("stale_dropped", 32'(bus.predInstrValid), 32'd0);
    tick();
    bus.icacheRespValid = 1'b0;
    #1;
    check_eq("post_discard_req", 32'(bus.icacheReqValid), 32'd1);
    check_eq("post_discard_addr", bus.icacheAddr, 32'h0000_0400);
    model_pc = 32'h0000_0400;
    fetch_to_issue(32'h0010_0093, K_OTHER, 32'd0, 1, 1'b0);

    // Flush and iqReady together in ISSUE: flush wins, target 0xFFFF_FFFC.
    void'(exp_q.pop_front());
    bus.flushIn = 1'b1;
    bus.flushPC = 32'hFFFF_FFFC;
    bus.iqReady = 1'b1;
    #1;
    check_eq("flush_issue_req", 32'(bus.icacheReqValid), 32'd0);
    tick();
    bus.flushIn = 1'b0;
    bus.iqReady = 1'b0;
    #1;
    check_eq("flush_kills_issue", 32'(bus.iqValid), 32'd0);
    model_pc = 32'hFFFF_FFFC;
    fetch_to_issue(enc_br(off), K_BR, off, 1, 1'b0);
    complete_transfer(1);
    check_eq("wrap_next", model_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of ISSUE.
    fetch_to_issue(32'h0020_0113, K_OTHER, 32'd0, 0, 1'b0);
    #1;
    resetIn = 1'b1;
    #1;
    check_eq("areset_iq_valid", 32'(bus.iqValid), 32'd0);
    check_eq("areset_req", 32'(bus.icacheReqValid), 32'd0);
    check_eq("areset_state", 32'(state), 32'(ST_FETCH));
    void'(exp_q.pop_front());
    tick();
    tick();
    resetIn = 1'b0;
    model_pc = RST_PC;
    fetch_to_issue(32'h0010_0093, K_OTHER, 32'd0, 2, 1'b1);
    complete_transfer(0);

    // Randomized stream with occasional idle-time redirects.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) redirect({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      kind = $urandom_range(0, 3);
      gen_instr(kind, ins, off);
      fetch_to_issue(ins, kind, off, $urandom_range(0, 4), 1'($urandom));
      complete_transfer($urandom_range(0, 3));
    end
    check_eq("final_addr", bus.icacheAddr, model_pc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
